// File: rtl/axilite_regbank.sv
// axilite_regbank: AXI4-Lite slave exposing NUM_REGS read/write registers.
//
// Parameters:
//   ADDR_WIDTH - AXI address width
//   DATA_WIDTH - data width (32 or 64)
//   NUM_REGS   - number of registers (2..256)
//   DATA_RESET - reset value of every register
//   ID_WIDTH   - transaction ID width
//
// Ports:
//   aclk, aresetn                    - clock, asynchronous active-low reset
//   awaddr/awvalid/awready/awid      - write address channel
//   wdata/wstrb/wvalid/wready        - write data channel
//   bresp/bvalid/bready/bid          - write response channel
//   araddr/arvalid/arready/arid      - read address channel
//   rdata/rresp/rvalid/rready/rid    - read data channel
//   reg_q                            - all registers, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
//   reg_wr                           - one-cycle pulse per register on a committed write
//
// Build option:
//   AXILITE_REGBANK_DECERR_EN - when defined, out-of-range accesses answer
//   DECERR; otherwise they answer OKAY (writes dropped, reads return 0).
module axilite_regbank #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           NUM_REGS   = 8,
  parameter logic [DATA_WIDTH-1:0] DATA_RESET = '0,
  parameter int unsigned           ID_WIDTH   = 4
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [ID_WIDTH-1:0]            awid,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  output logic [ID_WIDTH-1:0]            bid,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic                           arvalid,
  output logic                           arready,
  input  logic [ID_WIDTH-1:0]            arid,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [ID_WIDTH-1:0]            rid,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            reg_wr
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned LSB    = $clog2(STRB_W);
  localparam int unsigned IDX_W  = $clog2(NUM_REGS);
  localparam int unsigned HI_SH  = LSB + IDX_W;

  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXILITE_REGBANK_DECERR_EN
  localparam logic [1:0] RESP_OOR  = 2'b11;
`else
  localparam logic [1:0] RESP_OOR  = 2'b00;
`endif

  typedef enum logic {W_IDLE, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_RESP} rstate_e;

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
    return a[LSB +: IDX_W];
  endfunction

  // Out of range: index past the last register, or any bit above the index field set.
  function automatic logic addr_oor(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] hi;
    hi = a >> HI_SH;
    return (32'(addr_idx(a)) >= NUM_REGS) || (hi != '0);
  endfunction

  // Ready outputs stay low until the first clock edge after reset release.
  logic                  rdy_en_q, rdy_en_d;

  wstate_e               wstate_q, wstate_d;
  logic                  aw_got_q, aw_got_d;
  logic                  w_got_q, w_got_d;
  logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
  logic                  aw_oor_q, aw_oor_d;
  logic [ID_WIDTH-1:0]   awid_q, awid_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [ID_WIDTH-1:0]   bid_q, bid_d;
  logic [NUM_REGS-1:0]   reg_wr_q, reg_wr_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  rstate_e               rstate_q, rstate_d;
  logic                  rvalid_q, rvalid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  assign awready = rdy_en_q && (wstate_q == W_IDLE) && !aw_got_q;
  assign wready  = rdy_en_q && (wstate_q == W_IDLE) && !w_got_q;
  assign arready = rdy_en_q && (rstate_q == R_IDLE);
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign bid     = bid_q;
  assign rvalid  = rvalid_q;
  assign rresp   = rresp_q;
  assign rid     = rid_q;
  assign rdata   = rdata_q;
  assign reg_wr  = reg_wr_q;

  always_comb begin
    reg_q = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      reg_q[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end
  end

  // Write path: AW and W are latched independently; the commit happens one
  // cycle after both are held, which also raises bvalid.
  always_comb begin
    rdy_en_d = 1'b1;
    wstate_d = wstate_q;
    aw_got_d = aw_got_q;
    w_got_d  = w_got_q;
    aw_idx_d = aw_idx_q;
    aw_oor_d = aw_oor_q;
    awid_d   = awid_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    bid_d    = bid_q;
    reg_wr_d = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end

    case (wstate_q)
      W_IDLE: begin
        if (aw_got_q && w_got_q) begin
          if (!aw_oor_q) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
              if (aw_idx_q == IDX_W'(i)) begin
                reg_wr_d[i] = 1'b1;
                for (int unsigned b = 0; b < STRB_W; b++) begin
                  if (wstrb_q[b]) begin
                    regs_d[i][b*8 +: 8] = wdata_q[b*8 +: 8];
                  end
                end
              end
            end
          end
          bresp_d  = aw_oor_q ? RESP_OOR : RESP_OKAY;
          bid_d    = awid_q;
          bvalid_d = 1'b1;
          aw_got_d = 1'b0;
          w_got_d  = 1'b0;
          wstate_d = W_RESP;
        end else begin
          if (awvalid && awready) begin
            aw_got_d = 1'b1;
            aw_idx_d = addr_idx(awaddr);
            aw_oor_d = addr_oor(awaddr);
            awid_d   = awid;
          end
          if (wvalid && wready) begin
            w_got_d = 1'b1;
            wdata_d = wdata;
            wstrb_d = wstrb;
          end
        end
      end
      W_RESP: begin
        if (bready) begin
          bvalid_d = 1'b0;
          wstate_d = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  // Read path samples regs_q at the AR handshake, so a commit on the same
  // edge is not yet visible to the read.
  always_comb begin
    rstate_d = rstate_q;
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rid_d    = rid_q;
    rdata_d  = rdata_q;

    case (rstate_q)
      R_IDLE: begin
        if (arvalid && arready) begin
          rvalid_d = 1'b1;
          rid_d    = arid;
          rdata_d  = '0;
          if (addr_oor(araddr)) begin
            rresp_d = RESP_OOR;
          end else begin
            rresp_d = RESP_OKAY;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
              if (addr_idx(araddr) == IDX_W'(i)) begin
                rdata_d = regs_q[i];
              end
            end
          end
          rstate_d = R_RESP;
        end
      end
      R_RESP: begin
        if (rready) begin
          rvalid_d = 1'b0;
          rstate_d = R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rdy_en_q <= 1'b0;
      wstate_q <= W_IDLE;
      aw_got_q <= 1'b0;
      w_got_q  <= 1'b0;
      aw_idx_q <= '0;
      aw_oor_q <= 1'b0;
      awid_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= '0;
      bid_q    <= '0;
      reg_wr_q <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= DATA_RESET;
      end
      rstate_q <= R_IDLE;
      rvalid_q <= 1'b0;
      rresp_q  <= '0;
      rid_q    <= '0;
      rdata_q  <= '0;
    end else begin
      rdy_en_q <= rdy_en_d;
      wstate_q <= wstate_d;
      aw_got_q <= aw_got_d;
      w_got_q  <= w_got_d;
      aw_idx_q <= aw_idx_d;
      aw_oor_q <= aw_oor_d;
      awid_q   <= awid_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
      bid_q    <= bid_d;
      reg_wr_q <= reg_wr_d;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      rstate_q <= rstate_d;
      rvalid_q <= rvalid_d;
      rresp_q  <= rresp_d;
      rid_q    <= rid_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_axilite_regbank.sv
// Self-checking bench for axilite_regbank (default parameters). Expected
// values come from a word-array model addressed by addr/4.
module tb_axilite_regbank;

  localparam int unsigned NR = 8;
  localparam int unsigned DW = 32;
`ifdef AXILITE_REGBANK_DECERR_EN
  localparam logic [1:0] OOR_RESP = 2'b11;
`else
  localparam logic [1:0] OOR_RESP = 2'b00;
`endif

  logic            aclk, aresetn;
  logic [31:0]     awaddr, wdata, araddr, rdata;
  logic            awvalid, awready, wvalid, wready, bvalid, bready;
  logic            arvalid, arready, rvalid, rready;
  logic [3:0]      awid, bid, arid, rid, wstrb;
  logic [1:0]      bresp, rresp;
  logic [NR*DW-1:0] reg_q;
  logic [NR-1:0]   reg_wr;

  int tests = 0;
  int fails = 0;
  logic [31:0] mdl [NR];

  axilite_regbank dut (
    .aclk(aclk), .aresetn(aresetn),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready), .awid(awid),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready), .bid(bid),
    .araddr(araddr), .arvalid(arvalid), .arready(arready), .arid(arid),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready), .rid(rid),
    .reg_q(reg_q), .reg_wr(reg_wr)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NR*DW-1:0] mdl_flat();
    logic [NR*DW-1:0] f;
    for (int i = 0; i < NR; i++) f[i*DW +: DW] = mdl[i];
    return f;
  endfunction

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [3:0] id,
                          input int aw_dly, input int w_dly, input int b_dly);
    int cyc, pulses, bv_cnt;
    bit aw_done, w_done, got_b, seen_b, stable_ok, quiet_ok, wrong_idx;
    bit aw_hs, w_hs, b_hs, inr;
    logic [1:0] b_resp0;
    logic [3:0] b_id0;
    int unsigned idx;
    idx = addr / 4;
    inr = idx < NR;
    cyc = 0; pulses = 0; bv_cnt = 0;
    aw_done = 0; w_done = 0; got_b = 0; seen_b = 0;
    stable_ok = 1; quiet_ok = 1; wrong_idx = 0;
    b_resp0 = 'x; b_id0 = 'x;
    while (!got_b && cyc < 200) begin
      awvalid = (cyc >= aw_dly) && !aw_done;
      awaddr = addr; awid = id;
      wvalid = (cyc >= w_dly) && !w_done;
      wdata = data; wstrb = strb;
      bready = bvalid && (bv_cnt >= b_dly);
      if (reg_wr != '0) begin
        pulses += $countones(reg_wr);
        if (!inr || reg_wr != (8'(1) << idx)) wrong_idx = 1;
      end
      if (bvalid) begin
        if (!seen_b) begin
          seen_b = 1; b_resp0 = bresp; b_id0 = bid;
        end else if (bresp !== b_resp0 || bid !== b_id0) stable_ok = 0;
        if (awready || wready) quiet_ok = 0;
        bv_cnt++;
      end
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      b_hs  = bvalid && bready;
      step();
      if (aw_hs) aw_done = 1;
      if (w_hs) w_done = 1;
      got_b = b_hs;
      cyc++;
    end
    awvalid = 0; wvalid = 0; bready = 0;
    chk("b_handshake", got_b, 1);
    chk("bresp", b_resp0, inr ? 2'b00 : OOR_RESP);
    chk("bid", b_id0, id);
    chk("b_stable", stable_ok, 1);
    chk("ready_low_in_resp", quiet_ok, 1);
    chk("reg_wr_count", pulses, inr ? 1 : 0);
    chk("reg_wr_index", wrong_idx, 0);
    if (b_dly > 0) chk("b_held_cycles", bv_cnt, b_dly + 1);
    if (inr) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) mdl[idx] = (mdl[idx] & ~(32'hFF << (8*b))) | (data & (32'hFF << (8*b)));
    end
    chk("reg_q_after_write", reg_q, mdl_flat());
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input int r_dly);
    int cyc;
    bit stable_ok, inr;
    logic [31:0] d0;
    int unsigned idx;
    idx = addr / 4;
    inr = idx < NR;
    arvalid = 1; araddr = addr; arid = id;
    cyc = 0;
    while (!arready && cyc < 50) begin step(); cyc++; end
    chk("arready", arready, 1);
    step();
    arvalid = 0;
    cyc = 0;
    while (!rvalid && cyc < 50) begin step(); cyc++; end
    chk("rvalid", rvalid, 1);
    d0 = rdata;
    stable_ok = 1;
    for (int i = 0; i < r_dly; i++) begin
      step();
      if (!rvalid || rdata !== d0 || rid !== id) stable_ok = 0;
    end
    chk("r_stable", stable_ok, 1);
    chk("rdata", rdata, inr ? mdl[idx] : 32'h0);
    chk("rresp", rresp, inr ? 2'b00 : OOR_RESP);
    chk("rid", rid, id);
    rready = 1;
    step();
    rready = 0;
    chk("rvalid_drop", rvalid, 0);
  endtask

  initial begin
    logic [31:0] a, d, old;
    int op;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    awaddr = 0; wdata = 0; wstrb = 0; awid = 0; araddr = 0; arid = 0;
    for (int i = 0; i < NR; i++) mdl[i] = 32'h0;

    // Reset state
    aresetn = 0;
    step(); step();
    chk("reset_outputs", {awready, wready, arready, bvalid, rvalid, reg_wr,
                          bresp, rresp, bid, rid, rdata}, '0);
    chk("reset_regs", reg_q, mdl_flat());
    aresetn = 1;
    #1;
    chk("ready_before_edge", {awready, wready, arready}, 3'b000);
    step();
    chk("ready_after_edge", {awready, wready, arready}, 3'b111);

    // Basic write/read, then partial strobes
    do_write(32'h04, 32'hDEADBEEF, 4'hF, 4'd3, 0, 0, 0);
    do_read(32'h04, 4'd9, 0);
    do_write(32'h04, 32'h11223344, 4'h5, 4'd1, 0, 0, 0);
    chk("strb_merge", mdl[1], 32'hDE22BE44);
    do_read(32'h04, 4'd2, 2);

    // W leads AW by 3 cycles, bready held off 5 cycles
    do_write(32'h08, 32'hCAFEF00D, 4'hF, 4'd7, 3, 0, 5);
    // AW leads W
    do_write(32'h0C, 32'h01020304, 4'hF, 4'd4, 0, 2, 1);
    // Zero strobe, low address bits ignored
    do_write(32'h0B, 32'hFFFFFFFF, 4'h0, 4'd6, 0, 0, 0);
    do_read(32'h0A, 4'd1, 0);

    // Out of range: index past end, and high address bit set
    do_write(32'h40, 32'h55555555, 4'hF, 4'd2, 0, 0, 0);
    do_read(32'h40, 4'd5, 0);
    do_write(32'h1000_0004, 32'h66666666, 4'hF, 4'd8, 0, 0, 0);
    do_read(32'h1000_0004, 4'd3, 0);

    // Read sampled on the same edge as a commit returns the old value
    old = mdl[2];
    awvalid = 1; awaddr = 32'h08; awid = 4'd5;
    wvalid = 1; wdata = 32'h9ABCDEF0; wstrb = 4'hF;
    step();
    awvalid = 0; wvalid = 0;
    arvalid = 1; araddr = 32'h08; arid = 4'd6;
    chk("arready_concurrent", arready, 1);
    step();
    arvalid = 0;
    chk("conc_rvalid_bvalid", {rvalid, bvalid}, 2'b11);
    chk("conc_rdata_old", rdata, old);
    chk("conc_rid", rid, 4'd6);
    chk("conc_reg_wr", reg_wr, 8'b0000_0100);
    mdl[2] = 32'h9ABCDEF0;
    chk("conc_reg_q", reg_q, mdl_flat());
    bready = 1; rready = 1;
    step();
    bready = 0; rready = 0;
    chk("conc_done", {rvalid, bvalid}, 2'b00);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 9);
      if (op < 7) a = ($urandom_range(0, NR - 1) * 4) + $urandom_range(0, 3);
      else if (op == 7) a = 32'h20 + ($urandom_range(0, 15) * 4);
      else a = $urandom();
      d = $urandom();
      if ($urandom_range(0, 1) == 0)
        do_write(a, d, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      else
        do_read(a, 4'($urandom_range(0, 15)), $urandom_range(0, 3));
    end

    // Reset while a write response is pending
    awvalid = 1; awaddr = 32'h0C; awid = 4'd9;
    wvalid = 1; wdata = 32'h12345678; wstrb = 4'hF;
    step();
    awvalid = 0; wvalid = 0;
    step();
    chk("pending_bvalid", bvalid, 1);
    #2 aresetn = 0;
    #1;
    for (int i = 0; i < NR; i++) mdl[i] = 32'h0;
    chk("reset_bvalid", bvalid, 0);
    chk("reset_mid_regs", reg_q, mdl_flat());
    chk("reset_mid_ready", {awready, wready, arready}, 3'b000);
    step();
    aresetn = 1;
    step();
    chk("ready_after_reset", {awready, wready, arready}, 3'b111);
    do_write(32'h1C, 32'hA5A5A5A5, 4'hF, 4'd11, 1, 0, 2);
    do_read(32'h1C, 4'd12, 1);
    do_read(32'h0C, 4'd13, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axilite_regbank.md
AXILITE_REGBANK -- requirements
Module: axilite_regbank

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: AXI address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: data width; legal values 32 or 64.
REQ-003 SHALL have parameter NUM_REGS, default 8: register count; legal range 2..256.
REQ-004 SHALL have parameter DATA_RESET, default 0: reset value of every register.
REQ-005 SHALL have parameter ID_WIDTH, default 4: width of the transaction ID.
REQ-006 SHALL have port aclk, input, 1 bit: the single clock.
REQ-007 SHALL have port aresetn, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port awaddr, input, ADDR_WIDTH bits: write address.
REQ-009 SHALL have ports awvalid (input, 1 bit) and awready (output, 1 bit): write-address handshake.
REQ-010 SHALL have port awid, input, ID_WIDTH bits: write ID.
REQ-011 SHALL have port wdata, input, DATA_WIDTH bits: write data.
REQ-012 SHALL have port wstrb, input, DATA_WIDTH/8 bits: byte enables.
REQ-013 SHALL have ports wvalid (input, 1 bit) and wready (output, 1 bit): write-data handshake.
REQ-014 SHALL have ports bresp (output, 2 bits), bvalid (output, 1 bit), bready (input, 1 bit) and bid (output, ID_WIDTH bits): write response.
REQ-015 SHALL have port araddr, input, ADDR_WIDTH bits: read address.
REQ-016 SHALL have ports arvalid (input, 1 bit), arready (output, 1 bit) and arid (input, ID_WIDTH bits): read address and ID.
REQ-017 SHALL have ports rdata (output, DATA_WIDTH bits), rresp (output, 2 bits), rvalid (output, 1 bit), rready (input, 1 bit) and rid (output, ID_WIDTH bits): read data.
REQ-018 SHALL have port reg_q, output, NUM_REGS*DATA_WIDTH bits: all register contents; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-019 SHALL have port reg_wr, output, NUM_REGS bits: one-cycle pulse per register on each committed write.

Function
REQ-020 SHALL decode the register index from awaddr or araddr bits [LSB +: clog2(NUM_REGS)], where LSB = log2(DATA_WIDTH/8); low address bits SHALL be ignored.
REQ-021 SHALL treat an address as out of range if its index is >= NUM_REGS or any address bit above the index field is 1.
REQ-022 SHALL implement the write FSM with states W_IDLE, W_RESP.
- In W_IDLE, awready and wready SHALL each be high until that channel is captured; AW and W may arrive in either order or in the same cycle.
REQ-023 SHALL commit the write in the cycle after both AW and W are captured, then enter W_RESP.
- On commit, each byte SHALL be updated only where its wstrb bit is 1; wstrb=0 SHALL update nothing but still respond.
- On commit, reg_wr[idx] SHALL pulse high for 1 cycle for an in-range write.
- On commit, bvalid SHALL assert the following cycle, with bid = captured awid.
REQ-024 In W_RESP, bvalid, bresp and bid SHALL hold stable until bready is high; the FSM SHALL then return to W_IDLE, and awready/wready SHALL be low throughout W_RESP.
REQ-025 SHALL implement the read FSM with states R_IDLE (arready=1) and R_RESP.
- On an AR handshake, rdata, rresp and rid (= arid) SHALL be registered, and rvalid SHALL assert the next cycle.
- All three SHALL hold until rready, then return to R_IDLE.
REQ-026 SHALL run the read and write FSMs concurrently; a read sampled in the same cycle as a write commit to the same register SHALL return the pre-write value.
REQ-027 SHALL return OKAY (0) for every in-range access.

Reset
REQ-028 While aresetn=0, all registers SHALL be DATA_RESET, and awready, wready, arready, bvalid, rvalid, reg_wr, bresp, rresp, bid, rid and rdata SHALL be 0; both FSMs SHALL be in their IDLE state.
REQ-029 Reset asserted mid-transaction SHALL discard any captured AW/W/AR; awready/wready/arready SHALL go high on the first clock edge after release.

Configuration
REQ-030 With AXILITE_REGBANK_DECERR_EN defined, an out-of-range write SHALL change nothing, pulse no reg_wr and return bresp=DECERR (3); an out-of-range read SHALL return rdata=0 and rresp=DECERR.
REQ-031 Without AXILITE_REGBANK_DECERR_EN, out-of-range writes SHALL be silently dropped with bresp=OKAY, and out-of-range reads SHALL return rdata=0 with rresp=OKAY.

Verification
REQ-032 Write 0xDEADBEEF to 0x04 with wstrb=0xF and awid=3 -> reg_wr[1] pulses once, then bvalid with bresp=0 and bid=3; reading 0x04 returns 0xDEADBEEF.
REQ-033 Write 0x11223344 with wstrb=0x5 to reg 1 (holding 0xDEADBEEF) -> reg 1 becomes 0xDE22BE44.
REQ-034 W presented 3 cycles before AW, with bready held low 5 cycles -> a single commit; bvalid stays high and stable until bready rises; awready stays low meanwhile.
REQ-035 Access 0x40 with NUM_REGS=8 -> with the macro: bresp=3, rresp=3, rdata=0, no reg_wr; without it: bresp=0, rresp=0, and the registers are unchanged.
REQ-036 Assert aresetn=0 while bvalid is pending -> bvalid=0 immediately, all reg_q=DATA_RESET; after release, a new write completes normally.
